// File: rtl/alu_op_responder_pkg.sv
// rtl/alu_op_responder_pkg.sv - shared opcodes, FSM states and default width
package alu_op_responder_pkg;

   localparam int DEFAULT_WIDTH = 4;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_MUL = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - LSB-first shift-add multiplier, one B bit per cycle
// product is the accumulator plus the current partial term, so it is final while done is high.
module shift_add_multiplier
   import alu_op_responder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk_i,
   input  logic               reset_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_sha;
   logic [WIDTH-1:0]   r_b;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_running;
   logic [2*WIDTH-1:0] w_partial;
   logic [2*WIDTH-1:0] w_acc_next;

   // Counter parks at WIDTH when idle so nothing moves outside a run.
   assign w_running  = (r_cnt != CNT_FULL);
   assign w_partial  = r_b[0] ? r_sha : '0;
   assign w_acc_next = r_acc + w_partial;

   assign done    = w_running && (r_cnt == CNT_LAST);
   assign product = w_acc_next;

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         r_acc <= '0;
         r_sha <= '0;
         r_b   <= '0;
         r_cnt <= CNT_FULL;
      end else if (start) begin
         r_acc <= '0;
         r_sha <= {{WIDTH{1'b0}}, a};
         r_b   <= b;
         r_cnt <= '0;
      end else if (w_running) begin
         r_acc <= w_acc_next;
         r_sha <= r_sha << 1;
         r_b   <= r_b >> 1;
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/alu_op_responder.sv
// rtl/alu_op_responder.sv - flow-controlled add/multiply responder
// Owns the request/response handshake, the result register and the completion counter.
module alu_op_responder
   import alu_op_responder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk_i,
   input  logic               reset_n,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic               req_sel_i,
   input  logic [WIDTH-1:0]   req_a_i,
   input  logic [WIDTH-1:0]   req_b_i,
   output logic               rsp_valid_o,
   input  logic               rsp_ready_i,
   output logic [2*WIDTH-1:0] rsp_data_o,
   output logic               rsp_sel_o,
   output logic               busy_o,
   output logic [7:0]         op_count_o
);

   state_t             r_state;
   state_t             w_next_state;
   logic [2*WIDTH-1:0] r_result;
   logic               r_sel;
   logic [7:0]         r_count;

   logic               w_accept;
   logic               w_start;
   logic               w_mul_done;
   logic [2*WIDTH-1:0] w_product;
   logic [2*WIDTH-1:0] w_sum;

   assign w_accept = req_valid_i && (r_state == ST_IDLE);
   assign w_sum    = {{WIDTH{1'b0}}, req_a_i} + {{WIDTH{1'b0}}, req_b_i};

   shift_add_multiplier #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk_i   (clk_i),
      .reset_n (reset_n),
      .start   (w_start),
      .a       (req_a_i),
      .b       (req_b_i),
      .done    (w_mul_done),
      .product (w_product)
   );

   always_comb begin
      w_next_state = r_state;
      w_start      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (req_sel_i == OP_MUL) begin
                  w_next_state = ST_MUL;
                  w_start      = 1'b1;
               end else begin
                  w_next_state = ST_DONE;
               end
            end
         end
         ST_MUL:  if (w_mul_done) w_next_state = ST_DONE;
         ST_DONE: if (rsp_ready_i) w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_result <= '0;
         r_sel    <= 1'b0;
         r_count  <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) r_sel <= req_sel_i;
         if (w_accept && (req_sel_i == OP_ADD)) r_result <= w_sum;
         if ((r_state == ST_MUL) && w_mul_done) r_result <= w_product;
         if ((r_state == ST_DONE) && rsp_ready_i) r_count <= r_count + 8'd1;
      end
   end

   assign req_ready_o = (r_state == ST_IDLE);
   assign rsp_valid_o = (r_state == ST_DONE);
   assign busy_o      = (r_state != ST_IDLE);
   assign rsp_data_o  = r_result;
   assign rsp_sel_o   = r_sel;
   assign op_count_o  = r_count;

endmodule

// File: tb/tb_alu_op_responder.sv
// tb/tb_alu_op_responder.sv - self-checking bench for alu_op_responder
module tb_alu_op_responder;

   localparam int WIDTH = 4;

   logic             clk_i;
   logic             reset_n;
   logic             req_valid_i;
   logic             req_ready_o;
   logic             req_sel_i;
   logic [WIDTH-1:0] req_a_i;
   logic [WIDTH-1:0] req_b_i;
   logic             rsp_valid_o;
   logic             rsp_ready_i;
   logic [7:0]       rsp_data_o;
   logic             rsp_sel_o;
   logic             busy_o;
   logic [7:0]       op_count_o;

   int tests = 0;
   int fails = 0;
   int model_count = 0;

   alu_op_responder #(.WIDTH(WIDTH)) dut (
      .clk_i       (clk_i),
      .reset_n     (reset_n),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_sel_i   (req_sel_i),
      .req_a_i     (req_a_i),
      .req_b_i     (req_b_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_data_o  (rsp_data_o),
      .rsp_sel_o   (rsp_sel_o),
      .busy_o      (busy_o),
      .op_count_o  (op_count_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic       sel;
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int ref_op(input logic sel, input int a, input int b);
      int r;
      r = sel ? a * b : a + b;
      return r % 256;
   endfunction

   task automatic run_op(input logic sel, input logic [3:0] a, input logic [3:0] b,
                         input int hold, output logic [7:0] data, output logic rsel,
                         output int lat, output int busy_n);
      int exp;
      exp = ref_op(sel, int'(a), int'(b));
      check("req_ready_before", int'(req_ready_o), 1);
      req_valid_i = 1'b1;
      req_sel_i   = sel;
      req_a_i     = a;
      req_b_i     = b;
      lat    = 0;
      busy_n = 0;
      do begin
         @(posedge clk_i); #1;
         lat++;
         if (lat == 1) begin
            req_valid_i = 1'b0;
            req_a_i     = 4'($urandom);
            req_b_i     = 4'($urandom);
            req_sel_i   = 1'($urandom);
         end
         if (busy_o) busy_n++;
      end while (!rsp_valid_o && lat < 20);
      if (!rsp_valid_o) check("rsp_timeout", 0, 1);
      data = rsp_data_o;
      rsel = rsp_sel_o;
      for (int i = 0; i < hold; i++) begin
         req_valid_i = 1'b1;
         req_a_i     = 4'($urandom);
         req_b_i     = 4'($urandom);
         @(posedge clk_i); #1;
         if (busy_o) busy_n++;
         check("bp_valid", int'(rsp_valid_o), 1);
         check("bp_data", int'(rsp_data_o), exp);
         check("bp_req_ready", int'(req_ready_o), 0);
      end
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
      @(posedge clk_i); #1;
      rsp_ready_i = 1'b0;
      model_count = (model_count + 1) % 256;
      check("idle_after_hs", int'(req_ready_o), 1);
      check("valid_after_hs", int'(rsp_valid_o), 0);
      check("busy_after_hs", int'(busy_o), 0);
      check("op_count", int'(op_count_o), model_count);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      @(posedge clk_i); #1;
      reset_n = 1'b1;
      model_count = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] data;
      logic       rsel;
      int         lat;
      int         busy_n;
      int         seen;
      logic       s;
      logic [3:0] a;
      logic [3:0] b;
      int         hold;

      vecs[0] = '{1'b0, 4'd5,  4'd3,  8'd8};
      vecs[1] = '{1'b1, 4'd5,  4'd3,  8'd15};
      vecs[2] = '{1'b0, 4'd4,  4'd7,  8'd11};
      vecs[3] = '{1'b1, 4'd4,  4'd7,  8'd28};
      vecs[4] = '{1'b1, 4'd15, 4'd15, 8'd225};
      vecs[5] = '{1'b0, 4'd15, 4'd15, 8'd30};
      vecs[6] = '{1'b1, 4'd0,  4'd9,  8'd0};
      vecs[7] = '{1'b1, 4'd2,  4'd6,  8'd12};

      reset_n     = 1'b0;
      req_valid_i = 1'b0;
      req_sel_i   = 1'b0;
      req_a_i     = '0;
      req_b_i     = '0;
      rsp_ready_i = 1'b0;
      #12;
      check("rst_valid", int'(rsp_valid_o), 0);
      check("rst_data", int'(rsp_data_o), 0);
      check("rst_sel", int'(rsp_sel_o), 0);
      check("rst_busy", int'(busy_o), 0);
      check("rst_count", int'(op_count_o), 0);
      @(posedge clk_i); #1;
      reset_n = 1'b1;
      @(posedge clk_i); #1;
      check("rst_req_ready", int'(req_ready_o), 1);

      // Table vectors; operands are scrambled right after acceptance inside run_op.
      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].sel, vecs[i].a, vecs[i].b, 0, data, rsel, lat, busy_n);
         check($sformatf("vec%0d_data", i), int'(data), int'(vecs[i].exp));
         check($sformatf("vec%0d_model", i), int'(data),
               ref_op(vecs[i].sel, int'(vecs[i].a), int'(vecs[i].b)));
         check($sformatf("vec%0d_sel", i), int'(rsel), int'(vecs[i].sel));
         check($sformatf("vec%0d_latency", i), lat, vecs[i].sel ? WIDTH + 1 : 1);
         check($sformatf("vec%0d_busy", i), busy_n, vecs[i].sel ? WIDTH + 1 : 1);
      end

      // rsp_ready_i with nothing pending must not count.
      rsp_ready_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      rsp_ready_i = 1'b0;
      check("idle_ready_count", int'(op_count_o), model_count);
      check("idle_ready_valid", int'(rsp_valid_o), 0);

      // Backpressure with competing requests.
      run_op(1'b1, 4'd6, 4'd9, 6, data, rsel, lat, busy_n);
      check("bp_mul_data", int'(data), 54);
      check("bp_mul_busy", busy_n, WIDTH + 1 + 6);
      run_op(1'b0, 4'd9, 4'd12, 6, data, rsel, lat, busy_n);
      check("bp_add_data", int'(data), 21);
      @(posedge clk_i); #1;
      check("bp_no_stray_accept", int'(busy_o), 0);

      // Reset during the third MUL cycle.
      req_valid_i = 1'b1;
      req_sel_i   = 1'b1;
      req_a_i     = 4'd9;
      req_b_i     = 4'd13;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      check("mid_mul_busy", int'(busy_o), 1);
      repeat (2) @(posedge clk_i);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_valid", int'(rsp_valid_o), 0);
      check("mid_rst_data", int'(rsp_data_o), 0);
      check("mid_rst_sel", int'(rsp_sel_o), 0);
      check("mid_rst_busy", int'(busy_o), 0);
      check("mid_rst_count", int'(op_count_o), 0);
      @(posedge clk_i); #1;
      reset_n     = 1'b1;
      model_count = 0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk_i); #1;
         if (rsp_valid_o || busy_o) seen++;
      end
      check("mid_rst_no_rsp", seen, 0);
      run_op(1'b1, 4'd2, 4'd6, 0, data, rsel, lat, busy_n);
      check("post_rst_mul", int'(data), 12);

      // Randomised traffic against the arithmetic reference.
      for (int i = 0; i < 40; i++) begin
         s    = 1'($urandom_range(0, 1));
         a    = 4'($urandom_range(0, 15));
         b    = 4'($urandom_range(0, 15));
         hold = $urandom_range(0, 3);
         run_op(s, a, b, hold, data, rsel, lat, busy_n);
         check($sformatf("rnd%0d_data_%0d_%0d_%0d", i, s, a, b), int'(data),
               ref_op(s, int'(a), int'(b)));
         check($sformatf("rnd%0d_sel", i), int'(rsel), int'(s));
         check($sformatf("rnd%0d_latency", i), lat, s ? WIDTH + 1 : 1);
      end

      // Counter wrap over 256 handshakes.
      do_reset();
      check("wrap_start", int'(op_count_o), 0);
      for (int i = 0; i < 256; i++) begin
         a = 4'($urandom_range(0, 15));
         b = 4'($urandom_range(0, 15));
         run_op(1'b0, a, b, 0, data, rsel, lat, busy_n);
         if (i == 254) check("wrap_255", int'(op_count_o), 255);
      end
      check("wrap_zero", int'(op_count_o), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_op_responder.md
# alu_op_responder

Handshake-based responder for add/multiply operation requests. An initiator issues two operands and an operation select; the block returns a zero-extended sum after one cycle, or a shift-add product after WIDTH+1 cycles. It sits downstream of an operand sequencer, in place of a purely combinational add/multiply unit, wherever results must be flow-controlled.

## Interface

Parameters:
- WIDTH, 4, operand width; result width is 2*WIDTH.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  request ready; high only in IDLE.
- req_sel_i  input  1  operation: 0 = add, 1 = multiply.
- req_a_i  input  WIDTH  operand A, unsigned.
- req_b_i  input  WIDTH  operand B, unsigned.
- rsp_valid_o  output  1  response valid.
- rsp_ready_i  input  1  response accepted by the consumer.
- rsp_data_o  output  2*WIDTH  result.
- rsp_sel_o  output  1  operation that produced rsp_data_o.
- busy_o  output  1  high whenever state is not IDLE.
- op_count_o  output  8  completed responses, wraps 255 -> 0.

## Operation

- States: IDLE, MUL, DONE.
- IDLE: req_ready_o=1. On req_valid_i&&req_ready_o, latch A, B and sel.
  - sel=0: result register <= zero-extended A+B; go to DONE.
  - sel=1: clear the accumulator and set the iteration counter to 0; go to MUL.
- MUL: one bit of B per cycle, LSB first. If the current B bit is 1, accumulator += A shifted left by the iteration count. After WIDTH iterations, go to DONE. Requests are ignored.
- DONE: rsp_valid_o=1, and rsp_data_o/rsp_sel_o are held stable. On rsp_ready_i, go to IDLE and increment op_count_o. No request can be accepted in the cycle of the response handshake; the earliest next acceptance is the following cycle.
- Arithmetic: all operations are unsigned and no overflow is possible. The maximum sum is 2^(WIDTH+1)-2 and the maximum product is (2^WIDTH-1)^2, both within 2*WIDTH bits.
- Inputs are sampled only on the accept edge. Operand changes after acceptance have no effect on the operation in flight.
- Reset (asynchronous, any state, including mid-MUL) takes effect immediately:
  - state=IDLE;
  - rsp_valid_o=0, rsp_data_o=0, rsp_sel_o=0, op_count_o=0, busy_o=0;
  - req_ready_o=1 once reset is deasserted.
  - An operation in flight is discarded and produces no response.

## Timing

- Add latency: request accepted at edge k; rsp_valid_o is high after edge k+1.
- Multiply latency: rsp_valid_o is high after edge k+1+WIDTH (5 cycles for WIDTH=4).
- All outputs are registered or decoded directly from state; there is no combinational path from req_* to rsp_*.
- rsp_valid_o stays high, with data stable, for any number of cycles that rsp_ready_i stays low.
- rsp_ready_i while rsp_valid_o=0 has no effect.
- busy_o is high from the cycle after acceptance through the response handshake edge.
- op_count_o updates on the same edge that leaves DONE.

## Structure

- Shared header/package contents:
  - OP_ADD=1'b0 and OP_MUL=1'b1;
  - state encodings ST_IDLE, ST_MUL, ST_DONE;
  - default WIDTH.
- Sub-module shift_add_multiplier, which holds the accumulator, the shifted-A register and the iteration counter. Its interface is start, a, b, done and product. alu_op_responder owns the FSM, the handshake and op_count_o.
- The iteration counter is clog2(WIDTH+1) bits wide.

## Test plan

- Reset, then add 5 + 3 with rsp_ready_i=1: rsp_valid_o is high one cycle after acceptance, rsp_data_o=8'd8, rsp_sel_o=0, op_count_o=1.
- Multiply 5 * 3: busy_o high for 5 cycles, then rsp_data_o=8'd15 at latency 5. Operands are changed to 4 and 7 mid-MUL, and the result must still be 15.
- Add 4 + 7 gives 8'd11; multiply 4 * 7 gives 8'd28; boundary multiply 15 * 15 gives 8'd225; boundary add 15 + 15 gives 8'd30.
- Backpressure: hold rsp_ready_i=0 for 6 cycles after a response is ready.
  - rsp_valid_o and rsp_data_o stay stable.
  - req_ready_o=0 throughout.
  - A new req_valid_i during this window is not accepted.
  - Release rsp_ready_i: the block is back in IDLE on the next edge.
- Assert reset_n=0 during the third MUL cycle: all outputs are immediately 0, busy_o=0 and no response appears. A subsequent 2 * 6 multiply returns 12.
- 256 back-to-back add requests: op_count_o wraps to 0 after the 256th handshake.
